// File: rtl/jtkcpu_mul.sv
// jtkcpu_mul: sequential unsigned multiplier for the KONAMI-2 CPU core.
// Performs 8x8 (MUL, len=0) or 16x16 (LMUL, len=1) products, retiring
// BITS_PER_STEP multiplier bits per cen-qualified clock edge. Responds to
// the ALU start/busy handshake; results and flags change only on completion.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cen           clock enable; state advances only on edges with cen=1
//   op0, op1      multiplicand / multiplier (low byte only when len=0)
//   len           0 = 8x8, 1 = 16x16
//   start         request, sampled on a cen edge while idle
//   busy          multiply in progress
//   prod_hi/lo    32-bit product (prod_hi forced to 0 for 8x8)
//   c, z          carry (product MSB for the selected width), zero flag
module jtkcpu_mul #(
  parameter int BITS_PER_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [15:0] op0,
  input  logic [15:0] op1,
  input  logic        len,
  input  logic        start,
  output logic        busy,
  output logic [15:0] prod_hi,
  output logic [15:0] prod_lo,
  output logic        c,
  output logic        z
);

  localparam int BPS = BITS_PER_STEP;

  generate
    if (BPS != 1 && BPS != 2) begin : g_bad_bps
      $error("jtkcpu_mul: BITS_PER_STEP must be 1 or 2");
    end
  endgenerate

  localparam logic [4:0] N8  = 5'(8 / BPS);
  localparam logic [4:0] N16 = 5'(16 / BPS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] a_q;      // multiplicand, pre-shifted to the current bit position
  logic [15:0] b_q;      // remaining multiplier bits, consumed from the bottom
  logic [4:0]  cnt;      // steps left
  logic [31:0] acc;
  logic        len_q;
  logic        accept, step, done;
  logic [15:0] mask;
  logic [31:0] pp, acc_nxt;

  assign mask    = len ? 16'hFFFF : 16'h00FF;
  assign busy    = (state == RUN);
  assign pp      = a_q * {{(32-BPS){1'b0}}, b_q[BPS-1:0]};
  assign acc_nxt = acc + pp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (cen && start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (cen) begin
        step = 1'b1;
        if (cnt == 5'd1) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= 32'h0;
      b_q     <= 16'h0;
      cnt     <= 5'd0;
      acc     <= 32'h0;
      len_q   <= 1'b0;
      prod_hi <= 16'h0;
      prod_lo <= 16'h0;
      c       <= 1'b0;
      z       <= 1'b1;
    end else if (accept) begin
      a_q   <= {16'h0, op0 & mask};
      b_q   <= op1 & mask;
      cnt   <= len ? N16 : N8;
      acc   <= 32'h0;
      len_q <= len;
    end else if (step) begin
      acc <= acc_nxt;
      a_q <= a_q << BPS;
      b_q <= b_q >> BPS;
      cnt <= cnt - 5'd1;
      if (done) begin
        // Final partial product folds straight into the published result
        prod_hi <= len_q ? acc_nxt[31:16] : 16'h0;
        prod_lo <= acc_nxt[15:0];
        c       <= len_q ? acc_nxt[31] : acc_nxt[15];
        z       <= len_q ? (acc_nxt == 32'h0) : (acc_nxt[15:0] == 16'h0);
      end
    end
  end

endmodule

// File: tb/tb_jtkcpu_mul.sv
module tb_jtkcpu_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b1;
  logic [15:0] op0 = 16'h0;
  logic [15:0] op1 = 16'h0;
  logic        len = 1'b0;
  logic        start = 1'b0;

  logic        busy_o [2];
  logic [15:0] hi_o   [2];
  logic [15:0] lo_o   [2];
  logic        c_o    [2];
  logic        z_o    [2];

  // reference model state, one per DUT (index k uses BITS_PER_STEP=k+1)
  logic        m_busy [2];
  int          m_left [2];
  logic [31:0] m_pend [2];
  logic        m_len  [2];
  logic [15:0] m_hi   [2];
  logic [15:0] m_lo   [2];
  logic        m_c    [2];
  logic        m_z    [2];

  int  npass = 0;
  int  ntot  = 0;
  bit  cmp_en = 1'b0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      jtkcpu_mul #(.BITS_PER_STEP(g + 1)) u_dut (
        .clk(clk), .rst(rst), .cen(cen), .op0(op0), .op1(op1), .len(len),
        .start(start), .busy(busy_o[g]), .prod_hi(hi_o[g]), .prod_lo(lo_o[g]),
        .c(c_o[g]), .z(z_o[g])
      );

      // Model: product computed by plain arithmetic at acceptance, published
      // after a countdown of cen edges.
      always @(posedge clk or posedge rst) begin
        if (rst) begin
          m_busy[g] <= 1'b0;
          m_left[g] <= 0;
          m_pend[g] <= 32'h0;
          m_len[g]  <= 1'b0;
          m_hi[g]   <= 16'h0;
          m_lo[g]   <= 16'h0;
          m_c[g]    <= 1'b0;
          m_z[g]    <= 1'b1;
        end else if (cen) begin
          if (!m_busy[g]) begin
            if (start) begin
              m_busy[g] <= 1'b1;
              m_left[g] <= (len ? 16 : 8) / (g + 1);
              m_pend[g] <= 32'(op0 & (len ? 16'hFFFF : 16'h00FF)) *
                           32'(op1 & (len ? 16'hFFFF : 16'h00FF));
              m_len[g]  <= len;
            end
          end else if (m_left[g] == 1) begin
            m_busy[g] <= 1'b0;
            m_hi[g]   <= m_len[g] ? m_pend[g][31:16] : 16'h0;
            m_lo[g]   <= m_pend[g][15:0];
            m_c[g]    <= m_len[g] ? m_pend[g][31] : m_pend[g][15];
            m_z[g]    <= m_len[g] ? (m_pend[g] == 32'h0) : (m_pend[g][15:0] == 16'h0);
          end else begin
            m_left[g] <= m_left[g] - 1;
          end
        end
      end
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // per-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc_busy%0d", k), 32'(busy_o[k]), 32'(m_busy[k]));
        chk($sformatf("cyc_prod%0d", k), {hi_o[k], lo_o[k]}, {m_hi[k], m_lo[k]});
        chk($sformatf("cyc_cz%0d", k), {30'h0, c_o[k], z_o[k]}, {30'h0, m_c[k], m_z[k]});
      end
    end
  end

  task automatic wait_idle(output int l1, output int l2);
    int n;
    l1 = 0; l2 = 0; n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (busy_o[0]) l1++;
      if (busy_o[1]) l2++;
      if (!busy_o[0] && !busy_o[1]) break;
      n++;
    end
    if (n >= 200) begin
      ntot++;
      $display("FAIL wait_idle: busy still high after %0d cycles, required idle", n);
    end
  endtask

  task automatic mul(input logic l, input logic [15:0] a, input logic [15:0] b,
                     output int l1, output int l2);
    len = l; op0 = a; op1 = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle(l1, l2);
  endtask

  task automatic res_chk(input string name, input logic [31:0] p, input logic ec,
                         input logic ez, input int l1, input int l2,
                         input int e1, input int e2);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_prod%0d", name, k), {hi_o[k], lo_o[k]}, p);
      chk($sformatf("%s_c%0d", name, k), 32'(c_o[k]), 32'(ec));
      chk($sformatf("%s_z%0d", name, k), 32'(z_o[k]), 32'(ez));
    end
    chk({name, "_lat1"}, 32'(l1), 32'(e1));
    chk({name, "_lat2"}, 32'(l2), 32'(e2));
  endtask

  initial begin
    int l1, l2, n;
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy%0d", k), 32'(busy_o[k]), 32'h0);
      chk($sformatf("rst_prod%0d", k), {hi_o[k], lo_o[k]}, 32'h0);
      chk($sformatf("rst_cz%0d", k), {30'h0, c_o[k], z_o[k]}, 32'h1);
    end
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);

    mul(1'b0, 16'h00FF, 16'h00FF, l1, l2);
    res_chk("ff8", 32'h0000FE01, 1'b1, 1'b0, l1, l2, 8, 4);

    mul(1'b1, 16'hFFFF, 16'hFFFF, l1, l2);
    res_chk("ff16", 32'hFFFE0001, 1'b1, 1'b0, l1, l2, 16, 8);

    mul(1'b1, 16'h1234, 16'h0000, l1, l2);
    res_chk("zero", 32'h00000000, 1'b0, 1'b1, l1, l2, 16, 8);

    mul(1'b0, 16'hAB12, 16'hCD03, l1, l2);
    res_chk("mask", 32'h00000036, 1'b0, 1'b0, l1, l2, 8, 4);

    // handshake: start held high, operands change after acceptance
    len = 1'b0; op0 = 16'd3; op1 = 16'd5; start = 1'b1;
    @(posedge clk); #2;
    op0 = 16'd7; op1 = 16'd9;
    l1 = 0; n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!busy_o[0]) break;
      l1++; n++;
    end
    chk("hs_lat", 32'(l1), 32'd8);
    chk("hs_first", {hi_o[0], lo_o[0]}, 32'd15);
    @(negedge clk);
    chk("hs_reaccept", 32'(busy_o[0]), 32'h1);
    start = 1'b0;
    wait_idle(l1, l2);
    chk("hs_second0", {hi_o[0], lo_o[0]}, 32'd63);
    chk("hs_second1", {hi_o[1], lo_o[1]}, 32'd63);

    // cen gating: 1-0-1-0 during a 16x16
    len = 1'b1; op0 = 16'h0100; op1 = 16'h0100; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; cen = 1'b0;
    l1 = 0; n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!busy_o[0]) break;
      l1++; n++;
      @(posedge clk); #2 cen = ~cen;
    end
    cen = 1'b1;
    chk("cen_lat", 32'(l1), 32'd32);
    chk("cen_prod", {hi_o[0], lo_o[0]}, 32'h00010000);
    chk("cen_cz", {30'h0, c_o[0], z_o[0]}, 32'h0);
    wait_idle(l1, l2);

    // async reset mid-operation
    len = 1'b1; op0 = 16'h1234; op1 = 16'h5678; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst_busy%0d", k), 32'(busy_o[k]), 32'h0);
      chk($sformatf("arst_prod%0d", k), {hi_o[k], lo_o[k]}, 32'h0);
      chk($sformatf("arst_cz%0d", k), {30'h0, c_o[k], z_o[k]}, 32'h1);
    end
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    mul(1'b0, 16'd2, 16'd3, l1, l2);
    res_chk("post_rst", 32'd6, 1'b0, 1'b0, l1, l2, 8, 4);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
